// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
//   MODE_HOLD : keep every stage
//   MODE_SHR  : stage 0 takes sin_r, data moves toward stage DEPTH-1
//   MODE_SHL  : stage DEPTH-1 takes sin_l, data moves toward stage 0
//   MODE_LOAD : every stage takes its parallel-load slice
package shift_reg_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
endpackage

// File: rtl/shreg_stage.sv
// One WIDTH-bit stage of the universal shift register.
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   en_i         0 forces hold
//   mode_i       operation select (see shift_reg_pkg)
//   prev_i       neighbour at index k-1 (or sin_r for stage 0)
//   next_i       neighbour at index k+1 (or sin_l for the last stage)
//   par_i        parallel load slice for this stage
//   q_o          registered stage value
module shreg_stage
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] next_i,
  input  logic [WIDTH-1:0] par_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      case (mode_i)
        MODE_SHR:  q_d = prev_i;
        MODE_SHL:  q_d = next_i;
        MODE_LOAD: q_d = par_i;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register: DEPTH stages of WIDTH bits with
// hold / shift-right / shift-left / parallel load, plus a saturating fill
// counter that never decrements except on reset.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-low reset
//   en, mode     enable and 2-bit operation select
//   sin_r, sin_l serial inputs for right / left shifts
//   pin          parallel load data, stage k = pin[k*WIDTH +: WIDTH]
//   pout         all stages, stage k = pout[k*WIDTH +: WIDTH]
//   sout_r       last stage, sout_l first stage
//   fill, full   count of stages holding shifted/loaded data, fill == DEPTH
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int FW   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       sin_r,
  input  logic [WIDTH-1:0]       sin_l,
  input  logic [DEPTH*WIDTH-1:0] pin,
  output logic [DEPTH*WIDTH-1:0] pout,
  output logic [WIDTH-1:0]       sout_r,
  output logic [WIDTH-1:0]       sout_l,
  output logic [FW-1:0]          fill,
  output logic                   full
);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] stg;
  logic [DEPTH-1:0][WIDTH-1:0] par;
  logic [FW-1:0]               fill_q, fill_d;
  logic                        full_q, full_d;

  assign par = pin;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] prev_w, next_w;
    if (k == 0) begin : g_first
      assign prev_w = sin_r;
    end else begin : g_prev
      assign prev_w = stg[k-1];
    end
    if (k == DEPTH-1) begin : g_last
      assign next_w = sin_l;
    end else begin : g_next
      assign next_w = stg[k+1];
    end
    shreg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .rst_n  (reset),
      .en_i   (en),
      .mode_i (mode),
      .prev_i (prev_w),
      .next_i (next_w),
      .par_i  (par[k]),
      .q_o    (stg[k])
    );
  end

  // Both shift directions count toward fill; load marks every stage valid.
  always_comb begin
    fill_d = fill_q;
    if (en) begin
      case (mode)
        MODE_SHR, MODE_SHL: if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
        MODE_LOAD:          fill_d = FILL_MAX;
        default:            fill_d = fill_q;
      endcase
    end
    // full is registered from next-state so it rises on the same edge as fill.
    full_d = (fill_d == FILL_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      full_q <= full_d;
    end
  end

  assign pout   = stg;
  assign sout_r = stg[DEPTH-1];
  assign sout_l = stg[0];
  assign fill   = fill_q;
  assign full   = full_q;
endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ: a 1x4 instance and an 8x3 instance.
// Stimulus pushes hand-computed expected outputs after each edge; monitors
// pop and compare on the following falling edge.
module tb_shift_reg_univ;
  typedef struct {
    logic [23:0] pout;
    logic [7:0]  sr;
    logic [7:0]  sl;
    logic [2:0]  fill;
    logic        full;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t q4[$];
  exp_t q8[$];

  // 1-bit x 4 instance
  logic       rst4 = 1'b1, en4 = 1'b0;
  logic [1:0] md4 = 2'b00;
  logic [0:0] sr4 = '0, sl4 = '0, sor4, sol4;
  logic [3:0] pin4 = '0, pout4;
  logic [2:0] fill4;
  logic       full4;

  shift_reg_univ #(.WIDTH(1), .DEPTH(4)) dut4 (
    .clk(clk), .reset(rst4), .en(en4), .mode(md4), .sin_r(sr4), .sin_l(sl4),
    .pin(pin4), .pout(pout4), .sout_r(sor4), .sout_l(sol4), .fill(fill4), .full(full4)
  );

  // 8-bit x 3 instance
  logic        rst8 = 1'b1, en8 = 1'b0;
  logic [1:0]  md8 = 2'b00;
  logic [7:0]  sr8 = '0, sl8 = '0, sor8, sol8;
  logic [23:0] pin8 = '0, pout8;
  logic [1:0]  fill8;
  logic        full8;

  shift_reg_univ #(.WIDTH(8), .DEPTH(3)) dut8 (
    .clk(clk), .reset(rst8), .en(en8), .mode(md8), .sin_r(sr8), .sin_l(sl8),
    .pin(pin8), .pout(pout8), .sout_r(sor8), .sout_l(sol8), .fill(fill8), .full(full8)
  );

  exp_t e4, e8;

  always @(negedge clk) begin
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      checks++;
      if ({20'b0, pout4} !== e4.pout || {7'b0, sor4} !== e4.sr || {7'b0, sol4} !== e4.sl ||
          fill4 !== e4.fill || full4 !== e4.full) begin
        errors++;
        $display("FAIL %s: got pout=%h sr=%h sl=%h fill=%0d full=%b, want pout=%h sr=%h sl=%h fill=%0d full=%b",
                 e4.nm, pout4, sor4, sol4, fill4, full4, e4.pout[3:0], e4.sr[0], e4.sl[0], e4.fill, e4.full);
      end
    end
  end

  always @(negedge clk) begin
    if (q8.size() > 0) begin
      e8 = q8.pop_front();
      checks++;
      if (pout8 !== e8.pout || sor8 !== e8.sr || sol8 !== e8.sl ||
          {1'b0, fill8} !== e8.fill || full8 !== e8.full) begin
        errors++;
        $display("FAIL %s: got pout=%h sr=%h sl=%h fill=%0d full=%b, want pout=%h sr=%h sl=%h fill=%0d full=%b",
                 e8.nm, pout8, sor8, sol8, fill8, full8, e8.pout, e8.sr, e8.sl, e8.fill, e8.full);
      end
    end
  end

  // One edge on the 1x4 instance; glitch pulses reset low between edges.
  task automatic s4(input logic r, input logic e, input logic [1:0] m, input logic sr,
                    input logic sl, input logic [3:0] p, input logic glitch,
                    input logic [3:0] ep, input logic esr, input logic esl,
                    input logic [2:0] ef, input logic efu, input string nm);
    exp_t x;
    @(negedge clk); #1;
    rst4 = r; en4 = e; md4 = m; sr4 = sr; sl4 = sl; pin4 = p;
    if (glitch) begin
      rst4 = 1'b0; #2; rst4 = 1'b1;
    end
    @(posedge clk);
    x.pout = {20'b0, ep}; x.sr = {7'b0, esr}; x.sl = {7'b0, esl};
    x.fill = ef; x.full = efu; x.nm = nm;
    q4.push_back(x);
  endtask

  task automatic s8(input logic r, input logic e, input logic [1:0] m, input logic [7:0] sr,
                    input logic [7:0] sl, input logic [23:0] p, input logic [23:0] ep,
                    input logic [7:0] esr, input logic [7:0] esl, input logic [2:0] ef,
                    input logic efu, input string nm);
    exp_t x;
    @(negedge clk); #1;
    rst8 = r; en8 = e; md8 = m; sr8 = sr; sl8 = sl; pin8 = p;
    @(posedge clk);
    x.pout = ep; x.sr = esr; x.sl = esl; x.fill = ef; x.full = efu; x.nm = nm;
    q8.push_back(x);
  endtask

  initial begin
    //  rst en mode  sr sl pin     gl  pout    sr sl fill full
    s4(0, 1, 2'b01, 1, 1, 4'b1111, 0, 4'b0000, 0, 0, 3'd0, 0, "reset4");
    s4(1, 1, 2'b01, 1, 0, 4'b0000, 0, 4'b0001, 0, 1, 3'd1, 0, "shr1");
    s4(1, 1, 2'b01, 0, 0, 4'b0000, 0, 4'b0010, 0, 0, 3'd2, 0, "shr2");
    s4(1, 1, 2'b01, 1, 0, 4'b0000, 0, 4'b0101, 0, 1, 3'd3, 0, "shr3");
    s4(1, 1, 2'b01, 1, 0, 4'b0000, 0, 4'b1011, 1, 1, 3'd4, 1, "shr4_full");
    s4(1, 1, 2'b11, 0, 0, 4'b1001, 0, 4'b1001, 1, 1, 3'd4, 1, "load1001");
    s4(1, 1, 2'b10, 0, 0, 4'b0000, 0, 4'b0100, 0, 0, 3'd4, 1, "shl1");
    s4(1, 1, 2'b10, 0, 0, 4'b0000, 0, 4'b0010, 0, 0, 3'd4, 1, "shl2");
    s4(1, 0, 2'b01, 1, 1, 4'b1111, 0, 4'b0010, 0, 0, 3'd4, 1, "en0_a");
    s4(1, 0, 2'b01, 0, 1, 4'b1111, 0, 4'b0010, 0, 0, 3'd4, 1, "en0_b");
    s4(1, 0, 2'b01, 1, 1, 4'b1111, 0, 4'b0010, 0, 0, 3'd4, 1, "en0_c");
    s4(1, 1, 2'b00, 1, 1, 4'b1111, 0, 4'b0010, 0, 0, 3'd4, 1, "hold");
    s4(1, 1, 2'b01, 1, 0, 4'b0000, 0, 4'b0101, 0, 1, 3'd4, 1, "shr_sat");
    s4(0, 1, 2'b11, 0, 0, 4'b1111, 0, 4'b0000, 0, 0, 3'd0, 0, "reset_over_load");
    s4(1, 1, 2'b01, 1, 0, 4'b0000, 0, 4'b0001, 0, 1, 3'd1, 0, "shr_after_rst");
    s4(1, 1, 2'b00, 0, 0, 4'b0000, 1, 4'b0001, 0, 1, 3'd1, 0, "rst_glitch");
    s4(1, 1, 2'b10, 0, 1, 4'b0000, 0, 4'b1000, 1, 0, 3'd2, 0, "shl_mixed");
    s4(1, 1, 2'b01, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 3'd3, 0, "shr_mixed");

    //  rst en mode  sr     sl     pin        pout       sr     sl     fill  full
    s8(0, 1, 2'b11, 8'h00, 8'h00, 24'hFFFFFF, 24'h000000, 8'h00, 8'h00, 3'd0, 0, "reset8");
    s8(1, 1, 2'b01, 8'hA5, 8'h00, 24'h000000, 24'h0000A5, 8'h00, 8'hA5, 3'd1, 0, "w8_shr1");
    s8(1, 1, 2'b01, 8'h3C, 8'h00, 24'h000000, 24'h00A53C, 8'h00, 8'h3C, 3'd2, 0, "w8_shr2");
    s8(1, 1, 2'b01, 8'hFF, 8'h00, 24'h000000, 24'hA53CFF, 8'hA5, 8'hFF, 3'd3, 1, "w8_shr3");
    s8(1, 1, 2'b11, 8'h00, 8'h00, 24'h112233, 24'h112233, 8'h11, 8'h33, 3'd3, 1, "w8_load");
    s8(1, 1, 2'b10, 8'h00, 8'h44, 24'h000000, 24'h441122, 8'h44, 8'h22, 3'd3, 1, "w8_shl");

    repeat (3) @(negedge clk);
    if (q4.size() != 0 || q8.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", q4.size(), q8.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
